mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store sequencer sitting directly upstream of dmem.
//  Accepts byte/half/word load and store requests from the pipeline and
//  issues word-wide dmem cycles (addr/wrdata/MemRead/MemWrite, rddata back).
//  Sub-word stores become read-modify-write. Loads return aligned,
//  sign- or zero-extended data. Misaligned requests are flagged, not issued.
// PARAMETERS
//  ADDR_WORD  0  1: mem_addr = req_addr>>2 (word index); 0: mem_addr = req_addr & ~3
// PORTS
//  clock        in   1   single clock, all state updates on posedge
//  reset        in   1   asynchronous, active-high
//  req_valid    in   1   request present; sampled only while req_ready=1
//  req_write    in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; bits [7:0]/[15:0] used for byte/half
//  req_ready    out  1   1 in IDLE only
//  resp_done    out  1   one-cycle pulse, request complete
//  resp_err     out  1   valid with resp_done: misaligned/illegal, no access made
//  load_data    out  32  extended load result; valid from resp_done, held until next load
//  mem_addr     out  32  to dmem addr
//  mem_wrdata   out  32  to dmem wrdata
//  mem_read     out  1   to dmem MemRead
//  mem_write    out  1   to dmem MemWrite
//  mem_rddata   in   32  from dmem rddata; combinational, valid while mem_read=1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; internal regs cleared.
//  Accept: req_valid & req_ready at edge latches addr/size/write/unsigned/wdata.
//  Little-endian lanes: off = addr[1:0]; byte k = bits [8k+7:8k]; half at off 0 or 2.
//  Misaligned: size=01 & addr[0]; size=10 & addr[1:0]!=0; size=11. Go to RESP
//   with err=1; no mem_read/mem_write assert.
//  FSM:
//   IDLE -> misaligned: RESP | word store: WRITE | load or sub-word store: READ
//   READ: mem_read=1; at edge capture mem_rddata to rd_q.
//         load -> RESP; sub-word store -> WRITE
//   WRITE: mem_write=1; mem_wrdata = full req_wdata (word), or rd_q with the
//          addressed lane(s) replaced by req_wdata[7:0]/[15:0]; -> RESP
//   RESP: resp_done=1 (resp_err as latched), load_data updated on entry; -> IDLE
//  Latency from accept edge T: err/done T+1; word store, load T+2;
//   sub-word store T+3. Throughput: next request accepted in the IDLE cycle after RESP.
//  mem_addr driven from latched request throughout READ/WRITE.
//  mem_read/mem_write never both 1. Neither is asserted outside READ/WRITE.
//  mem_addr/mem_wrdata hold their last value when idle.
//  Load extension: byte/half sign bit = lane MSB unless req_unsigned. Word: no extension.
//  Stores never modify load_data.
//  req_valid while req_ready=0 is ignored; requester holds until accepted.
//  Reset mid-operation: returns to IDLE immediately. mem_write drops asynchronously.
//   A WRITE cycle cut by reset before its edge performs no store. No resp_done is issued.
// TESTING
//  1 sw addr=0x28 data=0x01270033 -> mem_write 1 cycle, mem_addr=0x28 (0x0A if
//    ADDR_WORD=1), wrdata=0x01270033, done at T+2, err=0
//  2 lw addr=0x28 after 1 -> mem_read 1 cycle, load_data=0x01270033 at done (T+2)
//  3 sb addr=0x29 data=0xAB, mem holds 0x01270033 -> READ then WRITE
//    wrdata=0x0127AB33, done at T+3
//  4 lb addr=0x29 -> 0xFFFFFFAB; lbu -> 0x000000AB; lh addr=0x2A -> 0x00000127
//  5 lh addr=0x29, sw addr=0x2A, size=11 -> done+err at T+1, mem_read/mem_write stay 0
//  6 reset asserted during WRITE of a sb -> mem_write drops at once, word unchanged,
//    no resp_done, req_ready=1

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of a word-wide dmem.
// Sub-word stores are performed as read-modify-write; loads are lane-aligned
// and sign/zero-extended; misaligned or illegal requests are answered with an
// error and never reach memory.
module mem_access_unit #(
    parameter bit ADDR_WORD = 1'b0  // 1: mem_addr is a word index, 0: byte address with [1:0]=0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_done,
    output logic        resp_err,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rddata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    state_e      state_q;
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;  // only the sub-word part is needed after accept

    logic        req_ready_q;
    logic        resp_done_q;
    logic        resp_err_q;
    logic [31:0] load_data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wrdata_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic        misaligned;
    logic [31:0] issue_addr;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Classify the incoming request and form the dmem address it would use.
    always_comb begin
        misaligned = (req_size == 2'b11)
                   || (req_size == SzHalf && req_addr[0])
                   || (req_size == SzWord && req_addr[1:0] != 2'b00);
        if (ADDR_WORD) begin
            issue_addr = {2'b00, req_addr[31:2]};
        end else begin
            issue_addr = {req_addr[31:2], 2'b00};
        end
    end

    // Align the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        rd_shift = mem_rddata >> {off_q, 3'b000};
        unique case (size_q)
            SzByte:  load_ext = unsigned_q ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SzHalf:  load_ext = unsigned_q ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = mem_rddata;
        endcase
    end

    // Replace the addressed lane(s) of the read word with the store data.
    always_comb begin
        merged = mem_rddata;
        if (size_q == SzByte) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Sequencer FSM; every output is registered so mem_write drops with reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_done_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            load_data_q  <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wrdata_q <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            resp_done_q <= 1'b0;
            resp_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        unsigned_q  <= req_unsigned;
                        size_q      <= req_size;
                        off_q       <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (misaligned) begin
                            state_q     <= StResp;
                            resp_done_q <= 1'b1;
                            resp_err_q  <= 1'b1;
                        end else if (req_write && req_size == SzWord) begin
                            state_q      <= StWrite;
                            mem_addr_q   <= issue_addr;
                            mem_wrdata_q <= req_wdata;
                            mem_write_q  <= 1'b1;
                        end else begin
                            state_q    <= StRead;
                            mem_addr_q <= issue_addr;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    mem_read_q <= 1'b0;
                    if (write_q) begin
                        state_q      <= StWrite;
                        mem_wrdata_q <= merged;
                        mem_write_q  <= 1'b1;
                    end else begin
                        state_q     <= StResp;
                        load_data_q <= load_ext;
                        resp_done_q <= 1'b1;
                    end
                end
                StWrite: begin
                    mem_write_q <= 1'b0;
                    state_q     <= StResp;
                    resp_done_q <= 1'b1;
                end
                StResp: begin
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_done  = resp_done_q;
    assign resp_err   = resp_err_q;
    assign load_data  = load_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wrdata = mem_wrdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small word memory behind it.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        resp_done;
    logic        resp_err;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rddata;

    mem_access_unit #(.ADDR_WORD(1'b0)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_done   (resp_done),
        .resp_err    (resp_err),
        .load_data   (load_data),
        .mem_addr    (mem_addr),
        .mem_wrdata  (mem_wrdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rddata  (mem_rddata)
    );

    always #5 clock = ~clock;

    // Word memory standing in for dmem.
    logic [31:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    assign mem_rddata = mem[mem_addr[5:2]];
    always @(posedge clock) if (mem_write) mem[mem_addr[5:2]] <= mem_wrdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        bit          err;
        logic [31:0] ld;
        int          t_acc;
        int          lat;
    } resp_t;

    acc_t  acc_q[$];
    resp_t resp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every dmem cycle and every response is matched against the queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_read && mem_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
            if (mem_read || mem_write) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", {31'd0, mem_write}, 32'hFFFF_FFFF);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    chk("access_kind", {31'd0, mem_write}, {31'd0, a.wr});
                    chk("mem_addr", mem_addr, a.addr);
                    if (a.wr) chk("mem_wrdata", mem_wrdata, a.data);
                end
            end
            if (resp_done) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                    chk("load_data", load_data, r.ld);
                    chk("latency", cyc - r.t_acc + 1, r.lat);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        wait_ready();
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // Issue one request and queue its expected dmem cycles and response.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit rd_acc, input bit wr_acc, input logic [31:0] wr_data,
                         input bit err, input int lat, input logic [31:0] ld);
        int n = 0;
        drive(wr, sz, uns, a, wd);
        if (rd_acc) acc_q.push_back('{wr: 1'b0, addr: {a[31:2], 2'b00}, data: 32'h0});
        if (wr_acc) acc_q.push_back('{wr: 1'b1, addr: {a[31:2], 2'b00}, data: wr_data});
        resp_q.push_back('{err: err, ld: ld, t_acc: cyc, lat: lat});
        while (resp_q.size() != 0 && n < 8) begin
            @(posedge clock);
            n++;
        end
        if (resp_q.size() != 0) begin
            chk("done_timeout", resp_q.size(), 32'd0);
            resp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_done", {31'd0, resp_done}, 32'd0);
        chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Word store, then word load.
        issue(1, 2'b10, 0, 32'h28, 32'h0127_0033, 0, 1, 32'h0127_0033, 0, 2, 32'h0);
        chk("mem_addr_hold", mem_addr, 32'h28);
        issue(0, 2'b10, 0, 32'h28, 32'h0, 1, 0, 32'h0, 0, 2, 32'h0127_0033);
        // Byte store read-modify-write; load_data untouched.
        issue(1, 2'b00, 0, 32'h29, 32'hFFFF_FFAB, 1, 1, 32'h0127_AB33, 0, 3, 32'h0127_0033);
        chk("mem_after_sb", mem[10], 32'h0127_AB33);
        // Sub-word loads with sign and zero extension.
        issue(0, 2'b00, 0, 32'h29, 32'h0, 1, 0, 32'h0, 0, 2, 32'hFFFF_FFAB);
        issue(0, 2'b00, 1, 32'h29, 32'h0, 1, 0, 32'h0, 0, 2, 32'h0000_00AB);
        issue(0, 2'b01, 0, 32'h2A, 32'h0, 1, 0, 32'h0, 0, 2, 32'h0000_0127);
        issue(0, 2'b01, 0, 32'h28, 32'h0, 1, 0, 32'h0, 0, 2, 32'hFFFF_AB33);
        // Upper half store, then loads from the new lanes.
        issue(1, 2'b01, 0, 32'h2A, 32'h1234_BEEF, 1, 1, 32'hBEEF_AB33, 0, 3, 32'hFFFF_AB33);
        issue(0, 2'b00, 0, 32'h2B, 32'h0, 1, 0, 32'h0, 0, 2, 32'hFFFF_FFBE);
        issue(0, 2'b01, 1, 32'h2A, 32'h0, 1, 0, 32'h0, 0, 2, 32'h0000_BEEF);
        issue(0, 2'b10, 0, 32'h28, 32'h0, 1, 0, 32'h0, 0, 2, 32'hBEEF_AB33);
        // Misaligned and illegal requests: error at T+1, no dmem cycle.
        issue(0, 2'b01, 0, 32'h29, 32'h0, 0, 0, 32'h0, 1, 1, 32'hBEEF_AB33);
        issue(1, 2'b10, 0, 32'h2A, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 1, 32'hBEEF_AB33);
        issue(0, 2'b11, 0, 32'h28, 32'h0, 0, 0, 32'h0, 1, 1, 32'hBEEF_AB33);

        // Reset during the WRITE cycle of a byte store.
        drive(1, 2'b00, 0, 32'h2B, 32'h0000_0055);
        acc_q.push_back('{wr: 1'b0, addr: 32'h28, data: 32'h0});
        @(posedge clock);
        #1;
        chk("in_write_phase", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_drops_write", {31'd0, mem_write}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_no_done", {31'd0, resp_done}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        chk("word_unchanged", mem[10], 32'hBEEF_AB33);
        chk("no_pending_access", acc_q.size(), 32'd0);
        issue(0, 2'b10, 0, 32'h28, 32'h0, 1, 0, 32'h0, 0, 2, 32'hBEEF_AB33);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
